// File: rtl/mux_arbiter_2_pkg.sv
// Shared types and defaults for the two-requester round-robin mux arbiter.
package mux_arbiter_2_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGrant0 = 2'd1,
        StGrant1 = 2'd2,
        StTurn   = 2'd3
    } state_e;

    localparam int unsigned DefMaxHold   = 8;
    localparam int unsigned DefHoldWidth = 4;

endpackage

// File: rtl/mux_arbiter_2_hold_counter.sv
// Grant hold counter: clears outside a grant, counts grant cycles, saturates at MaxHold-1.
module hold_counter #(
    parameter int unsigned MaxHold   = mux_arbiter_2_pkg::DefMaxHold,
    parameter int unsigned HoldWidth = mux_arbiter_2_pkg::DefHoldWidth
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_at_limit
);

    localparam bit PreemptEn = (MaxHold != 0);
    // With preemption disabled the count simply parks at all-ones.
    localparam logic [HoldWidth-1:0] Limit =
        PreemptEn ? HoldWidth'(MaxHold - 1) : {HoldWidth{1'b1}};

    logic [HoldWidth-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != Limit)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_at_limit = PreemptEn && (r_count == Limit);

endmodule

// File: rtl/mux_arbiter_2.sv
// Round-robin arbiter driving the Sel/Enable pins of a shared 2:1 mux, with one dead
// turnaround cycle between owners and optional timeout preemption.
module mux_arbiter_2
    import mux_arbiter_2_pkg::*;
#(
    parameter int unsigned MaxHold   = DefMaxHold,
    parameter int unsigned HoldWidth = DefHoldWidth
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic Req_0,
    input  logic Req_1,
    output logic Grant_0,
    output logic Grant_1,
    output logic MuxSel,
    output logic MuxEnable,
    output logic Preempt
);

    state_e r_state, w_state_next;
    logic   r_last_owner, w_last_owner_next;
    logic   r_next_owner, w_next_owner_next;
    logic   w_preempt_next;
    logic   w_at_limit;
    logic   w_in_grant;
    logic   r_grant_0, r_grant_1, r_mux_sel, r_mux_enable, r_preempt;

    assign w_in_grant = (r_state == StGrant0) || (r_state == StGrant1);

    hold_counter #(
        .MaxHold   (MaxHold),
        .HoldWidth (HoldWidth)
    ) u_hold_counter (
        .i_clk      (Clock),
        .i_rst_n    (Reset_n),
        .i_clear    (!w_in_grant),
        .i_inc      (w_in_grant),
        .o_at_limit (w_at_limit)
    );

    always_comb begin
        w_state_next      = r_state;
        w_last_owner_next = r_last_owner;
        w_next_owner_next = r_next_owner;
        w_preempt_next    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (Req_0 && Req_1) begin
                    w_state_next = r_last_owner ? StGrant0 : StGrant1;
                end else if (Req_0) begin
                    w_state_next = StGrant0;
                end else if (Req_1) begin
                    w_state_next = StGrant1;
                end
            end
            StGrant0: begin
                // Release takes priority over a coincident timeout.
                if (!Req_0) begin
                    w_last_owner_next = 1'b0;
                    w_next_owner_next = 1'b1;
                    w_state_next      = Req_1 ? StTurn : StIdle;
                end else if (w_at_limit && Req_1) begin
                    w_last_owner_next = 1'b0;
                    w_next_owner_next = 1'b1;
                    w_state_next      = StTurn;
                    w_preempt_next    = 1'b1;
                end
            end
            StGrant1: begin
                if (!Req_1) begin
                    w_last_owner_next = 1'b1;
                    w_next_owner_next = 1'b0;
                    w_state_next      = Req_0 ? StTurn : StIdle;
                end else if (w_at_limit && Req_0) begin
                    w_last_owner_next = 1'b1;
                    w_next_owner_next = 1'b0;
                    w_state_next      = StTurn;
                    w_preempt_next    = 1'b1;
                end
            end
            StTurn: begin
                w_state_next = r_next_owner ? StGrant1 : StGrant0;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= StIdle;
            r_last_owner <= 1'b1;
            r_next_owner <= 1'b0;
            r_grant_0    <= 1'b0;
            r_grant_1    <= 1'b0;
            r_mux_sel    <= 1'b0;
            r_mux_enable <= 1'b0;
            r_preempt    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_last_owner <= w_last_owner_next;
            r_next_owner <= w_next_owner_next;
            r_grant_0    <= (w_state_next == StGrant0);
            r_grant_1    <= (w_state_next == StGrant1);
            r_mux_enable <= (w_state_next == StGrant0) || (w_state_next == StGrant1);
            r_preempt    <= w_preempt_next;
            if (w_state_next == StGrant0) begin
                r_mux_sel <= 1'b0;
            end else if (w_state_next == StGrant1) begin
                r_mux_sel <= 1'b1;
            end
        end
    end

    assign Grant_0   = r_grant_0;
    assign Grant_1   = r_grant_1;
    assign MuxSel    = r_mux_sel;
    assign MuxEnable = r_mux_enable;
    assign Preempt   = r_preempt;

endmodule

// File: tb/tb_mux_arbiter_2.sv
// Directed self-checking bench for mux_arbiter_2 with MaxHold=4.
module tb_mux_arbiter_2;

    logic Clock;
    logic Reset_n;
    logic Req_0;
    logic Req_1;
    logic Grant_0;
    logic Grant_1;
    logic MuxSel;
    logic MuxEnable;
    logic Preempt;

    int n_cmp;
    int n_err;

    // Observed output vector: {Grant_0, Grant_1, MuxSel, MuxEnable, Preempt}
    logic [4:0] obs;
    assign obs = {Grant_0, Grant_1, MuxSel, MuxEnable, Preempt};

    mux_arbiter_2 #(
        .MaxHold   (4),
        .HoldWidth (4)
    ) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Req_0     (Req_0),
        .Req_1     (Req_1),
        .Grant_0   (Grant_0),
        .Grant_1   (Grant_1),
        .MuxSel    (MuxSel),
        .MuxEnable (MuxEnable),
        .Preempt   (Preempt)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one rising edge and settle; inputs driven afterwards apply to the next edge.
    task automatic tick();
        @(posedge Clock);
        #1;
        n_cmp++;
        if (Grant_0 && Grant_1) begin
            n_err++;
            $display("FAIL mutex: Grant_0=%b Grant_1=%b, required not both high", Grant_0, Grant_1);
        end
        n_cmp++;
        if (MuxEnable !== (Grant_0 | Grant_1)) begin
            n_err++;
            $display("FAIL enable_or: MuxEnable=%b, required %b", MuxEnable, Grant_0 | Grant_1);
        end
    endtask

    task automatic do_reset();
        #2;
        Reset_n = 1'b0;
        #2;
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        Req_0   = 1'b0;
        Req_1   = 1'b0;
        #2;
        n_cmp++;
        if (obs !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b, required 00000", obs);
        end
        n_cmp++;
        if (dut.u_hold_counter.r_count !== 4'd0) begin
            n_err++;
            $display("FAIL reset_holdcnt: got %0d, required 0", dut.u_hold_counter.r_count);
        end
        #10;
        Reset_n = 1'b1;
        tick();
        n_cmp++;
        if (obs !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_idle: got %b, required 00000", obs);
        end
    endtask

    task automatic test_single();
        Req_0 = 1'b1;
        tick();
        n_cmp++;
        if (obs !== 5'b10010) begin
            n_err++;
            $display("FAIL single_grant0: got %b, required 10010", obs);
        end
        Req_0 = 1'b0;
        tick();
        n_cmp++;
        if (obs !== 5'b00000) begin
            n_err++;
            $display("FAIL single_release: got %b, required 00000", obs);
        end
    endtask

    task automatic test_tie();
        do_reset();
        Req_0 = 1'b1;
        Req_1 = 1'b1;
        tick();
        n_cmp++;
        if (obs !== 5'b10010) begin
            n_err++;
            $display("FAIL tie_first: got %b, required 10010", obs);
        end
        Req_0 = 1'b0;
        tick();
        n_cmp++;
        if (obs !== 5'b00000) begin
            n_err++;
            $display("FAIL tie_turn: got %b, required 00000", obs);
        end
        tick();
        n_cmp++;
        if (obs !== 5'b01110) begin
            n_err++;
            $display("FAIL tie_grant1: got %b, required 01110", obs);
        end
        Req_1 = 1'b0;
        tick();
        n_cmp++;
        if (obs !== 5'b00100) begin
            n_err++;
            $display("FAIL tie_idle: got %b, required 00100 (sel held)", obs);
        end
        Req_0 = 1'b1;
        Req_1 = 1'b1;
        tick();
        n_cmp++;
        if (obs !== 5'b10010) begin
            n_err++;
            $display("FAIL tie_round_robin: got %b, required 10010", obs);
        end
        Req_0 = 1'b0;
        Req_1 = 1'b0;
        tick();
        n_cmp++;
        if (obs !== 5'b00000) begin
            n_err++;
            $display("FAIL tie_drop: got %b, required 00000", obs);
        end
    endtask

    task automatic test_preempt();
        logic [4:0] exp_grant;
        logic [4:0] exp_turn;
        do_reset();
        Req_0 = 1'b1;
        Req_1 = 1'b1;
        for (int r = 0; r < 3; r++) begin
            exp_grant = (r % 2 == 0) ? 5'b10010 : 5'b01110;
            exp_turn  = (r % 2 == 0) ? 5'b00001 : 5'b00101;
            for (int k = 0; k < 4; k++) begin
                tick();
                n_cmp++;
                if (obs !== exp_grant) begin
                    n_err++;
                    $display("FAIL preempt_grant r%0d c%0d: got %b, required %b",
                             r, k, obs, exp_grant);
                end
            end
            tick();
            n_cmp++;
            if (obs !== exp_turn) begin
                n_err++;
                $display("FAIL preempt_turn r%0d: got %b, required %b", r, obs, exp_turn);
            end
        end
        // TURN grants Next unconditionally even though both requests dropped.
        Req_0 = 1'b0;
        Req_1 = 1'b0;
        tick();
        n_cmp++;
        if (obs !== 5'b01110) begin
            n_err++;
            $display("FAIL preempt_forced_grant: got %b, required 01110", obs);
        end
        tick();
        n_cmp++;
        if (obs !== 5'b00100) begin
            n_err++;
            $display("FAIL preempt_end_idle: got %b, required 00100", obs);
        end
    endtask

    task automatic test_hold_alone();
        do_reset();
        Req_1 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_cmp++;
            if (obs !== 5'b01110) begin
                n_err++;
                $display("FAIL alone_grant c%0d: got %b, required 01110", k, obs);
            end
        end
        n_cmp++;
        if (dut.u_hold_counter.r_count !== 4'd3) begin
            n_err++;
            $display("FAIL alone_saturate: got %0d, required 3", dut.u_hold_counter.r_count);
        end
    endtask

    task automatic test_reset_mid();
        // Entered with Req_1 high and Grant_1 owned.
        #2;
        Reset_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 5'b00000) begin
            n_err++;
            $display("FAIL midreset_drop: got %b, required 00000", obs);
        end
        #1;
        Reset_n = 1'b1;
        tick();
        n_cmp++;
        if (obs !== 5'b01110) begin
            n_err++;
            $display("FAIL midreset_regrant: got %b, required 01110", obs);
        end
        Req_1 = 1'b0;
        tick();
    endtask

    task automatic test_release_at_limit();
        do_reset();
        Req_0 = 1'b1;
        Req_1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if (obs !== 5'b10010) begin
                n_err++;
                $display("FAIL limit_grant c%0d: got %b, required 10010", k, obs);
            end
        end
        Req_0 = 1'b0;
        tick();
        n_cmp++;
        if (obs !== 5'b00000) begin
            n_err++;
            $display("FAIL limit_turn_no_preempt: got %b, required 00000", obs);
        end
        tick();
        n_cmp++;
        if (obs !== 5'b01110) begin
            n_err++;
            $display("FAIL limit_grant1: got %b, required 01110", obs);
        end
        Req_1 = 1'b0;
        tick();
        n_cmp++;
        if (obs !== 5'b00100) begin
            n_err++;
            $display("FAIL limit_idle: got %b, required 00100", obs);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_tie();
        test_preempt();
        test_hold_alone();
        test_reset_mid();
        test_release_at_limit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_arbiter_2.md
# mux_arbiter_2

Two-requester round-robin arbiter that owns the `Sel`/`Enable` pins of a shared 2:1 bus multiplexer. It sits beside the mux on a shared resource port, for example the single memory port contended by instruction fetch and data access. It grants one requester at a time, inserts one dead turnaround cycle between owners, and can preempt an owner that holds the bus too long while the other side waits.

## Interface
Parameters:
- `MaxHold`, default 8: maximum cycles an owner keeps the grant while the other side requests. 0 disables preemption.
- `HoldWidth`, default 4: hold-counter width. Must satisfy `MaxHold` ≤ 2^`HoldWidth` − 1.

Ports:
- `Clock` input 1: single clock, rising edge.
- `Reset_n` input 1: asynchronous, active-low reset.
- `Req_0` input 1: requester 0 wants the bus. Level signal, held until done.
- `Req_1` input 1: requester 1 wants the bus. Level signal, held until done.
- `Grant_0` output 1: requester 0 owns the bus this cycle.
- `Grant_1` output 1: requester 1 owns the bus this cycle.
- `MuxSel` output 1: drives mux `Sel`. 0 selects `MuxIn_0`, 1 selects `MuxIn_1`.
- `MuxEnable` output 1: drives mux `Enable`. Mux output is 0 when low.
- `Preempt` output 1: one-cycle pulse in the first TURN cycle caused by a timeout.

## Operation
- States:
  - IDLE: no owner.
  - GRANT0: requester 0 owns the bus.
  - GRANT1: requester 1 owns the bus.
  - TURN: dead cycle, no owner.
- Internal registers:
  - `LastOwner` (1 bit): last requester that owned the bus.
  - `Next` (1 bit): requester to be granted after TURN.
  - `HoldCnt` (`HoldWidth` bits): cycles spent in the current grant.
- All outputs are registered and decoded from state only.
  - IDLE/TURN: `Grant_0`=`Grant_1`=`MuxEnable`=0. `MuxSel` keeps its last value.
  - GRANTx: `Grant_x`=1, `MuxEnable`=1, `MuxSel`=x.
- IDLE transitions:
  - Only `Req_0` high → GRANT0.
  - Only `Req_1` high → GRANT1.
  - Both high → GRANT to the requester ≠ `LastOwner`.
- GRANTx, owner drops `Req_x` (release):
  - Other requester high → TURN with `Next`=other.
  - Other requester low → IDLE.
  - Either way `LastOwner`=x.
- GRANTx preemption: `MaxHold`≠0, `HoldCnt`==`MaxHold`−1 and other requester high → TURN with `Next`=other, `LastOwner`=x, `Preempt` pulse.
  - The preempted owner keeps `Req_x` high and is regranted later under round-robin.
- TURN → GRANT`Next` unconditionally, even if that request has since dropped.
  - The new owner then releases normally, next cycle.
- `HoldCnt`:
  - Cleared on entry to GRANTx.
  - Increments each GRANTx cycle.
  - Saturates at `MaxHold`−1; never wraps.
- Owner alone on the bus, other side idle: the grant is held indefinitely and `HoldCnt` saturates.
- Release and preemption in the same cycle: treated as release, no `Preempt` pulse.

## Timing
- Reset (asynchronous assert, `Reset_n`=0):
  - state=IDLE, `LastOwner`=1 (requester 0 wins the first tie), `HoldCnt`=0, `MuxSel`=0.
  - All other outputs 0 immediately, without waiting for a clock edge.
- Deassertion of `Reset_n` is synchronised externally. The first decision occurs on the first rising edge after release.
- Grant latency from IDLE: 1 cycle. Request sampled at edge N, grant visible after edge N.
- Handover latency: owner drops `Req` at edge N → TURN after N → new grant after N+1. Exactly one dead cycle, never zero.
- Preemption: grant visible for exactly `MaxHold` cycles, then 1 TURN cycle.
- `Grant_0` and `Grant_1` are never high together.
- `MuxEnable`==`Grant_0` | `Grant_1` in every cycle.
- Reset asserted mid-grant: grant and `MuxEnable` drop asynchronously. No `Preempt` pulse.

## Structure
- Shared include `mux_arbiter_defs.vh`:
  - State encodings `ST_IDLE`=2'd0, `ST_GRANT0`=2'd1, `ST_GRANT1`=2'd2, `ST_TURN`=2'd3.
  - Default `MaxHold`/`HoldWidth`.
- One sub-module `hold_counter`:
  - Clear/increment/saturate counter with asynchronous active-low reset.
  - Output `AtLimit`.
  - Parameters `MaxHold` and `HoldWidth`.
- The top level holds the FSM, `LastOwner`/`Next` and the output registers.
- The top level connects to the existing 2:1 mux; it does not instantiate the mux.

## Test plan
- Reset, then `Req_0`=1 alone → `Grant_0`=1, `MuxSel`=0, `MuxEnable`=1 one cycle later. Drop `Req_0` → IDLE next cycle, all outputs 0.
- From reset, `Req_0` and `Req_1` rise on the same edge → `Grant_0` first.
  - Release → one TURN cycle with `MuxEnable`=0 → `Grant_1`, `MuxSel`=1.
  - Next tie from IDLE → `Grant_0`, round-robin.
- `MaxHold`=4, both requesters held high → `Grant_0` for exactly 4 cycles, `Preempt` pulse, 1 TURN cycle, then `Grant_1` for 4 cycles. Alternation continues; grants never overlap.
- `MaxHold`=4, only `Req_1` high for 20 cycles → `Grant_1` held all 20 cycles, no `Preempt`, `HoldCnt` saturates at 3.
- `Reset_n` pulsed low between clock edges during GRANT1 → `Grant_1` and `MuxEnable` fall immediately. After release with `Req_1`=1 → `Grant_1` one cycle later.
- Owner releases in the exact cycle `HoldCnt`==`MaxHold`−1 while the other requests → TURN, no `Preempt`, then grant to the other requester.
